quad_bus_arbiter: RTL and testbench
===================================

// Module: quad_bus_arbiter
// PURPOSE
//   Round-robin arbiter that shares one N-bit 4:1 multiplexer between four requesters.
//   It drives the mux select bits (B,A) and a one-hot grant, and registers the mux output.
//   A timeout limits how long one requester can hold the bus. Sits between the requesting
//   SoC masters and the shared 4:1 N-bit mux / destination bus.
// PARAMETERS
//   N         4   data width of D0..D3 and Y
//   HOLD_MAX  8   max consecutive cycles one grant may last (>=2); hold counter width = clog2(HOLD_MAX)
// PORTS
//   clk        in   1   single clock, all state updates on rising edge
//   reset      in   1   synchronous, active-high reset
//   req        in   4   req[i]=1: requester i wants the bus; held high for the whole tenure
//   D0..D3     in   N   requester data, routed through the shared 4:1 mux
//   A          out  1   mux select LSB; {B,A}=index of granted requester
//   B          out  1   mux select MSB
//   grant      out  4   one-hot grant, all-zero when idle
//   Y          out  N   registered mux output, i.e. D{B,A} one cycle after selection
//   bus_valid  out  1   Y holds data from a granted requester
//   timeout    out  1   one-cycle pulse when a tenure is cut at HOLD_MAX
// BEHAVIOUR
//   Reset (sync, at rising edge with reset=1):
//     state=IDLE, grant=0, A=B=0, Y=0, bus_valid=0, timeout=0, hold_cnt=0, ptr=0.
//     Applies mid-tenure: grant drops on the next edge; no data or pointer is retained.
//   ptr: the highest-priority index for the next arbitration. Search order is
//     ptr, ptr+1, ... mod 4, and the first requester with req set in that order wins.
//     Each new grant to index i sets ptr=(i+1) mod 4, wrapping 3->0.
//   FSM:
//     IDLE: grant=0.
//       - If req!=0 at an edge: grant the RR winner, A/B=its index, hold_cnt=0, go to BUSY.
//       - Otherwise stay in IDLE.
//       - Latency from req rising to grant is 1 cycle.
//     BUSY (grantee g):
//       - req[g]=1 and hold_cnt<HOLD_MAX-1: keep the grant and increment hold_cnt.
//       - req[g]=0 (release): if any other req is set, grant the RR winner on the same edge
//         (no idle bubble). Otherwise go to IDLE with grant=0.
//       - req[g]=1 and hold_cnt==HOLD_MAX-1: pulse timeout for 1 cycle. Grant the RR winner;
//         since ptr=g+1, g has the lowest priority. If g is the only requester, g is
//         re-granted immediately with hold_cnt=0 and timeout still pulses.
//   Pipeline:
//     - Each edge: Y <= D{B,A}, using the current select; bus_valid <= (state==BUSY).
//     - Y and bus_valid therefore lag grant/select by exactly one cycle.
//     - On a handoff, the first Y after the switch still carries the old grantee's data.
//     - When bus_valid=0, Y holds its last value.
//   Invariants:
//     - grant is one-hot or zero.
//     - {B,A} is always consistent with grant, and B/A keep their last value when idle.
//     - Changing req in the middle of a tenure never changes grant except under the rules above.
// TESTING
//   1. Reset: assert reset 1 cycle -> grant=0, A=B=0, Y=0, bus_valid=0, timeout=0.
//   2. Single request: req=0010 -> next edge grant=0010, {B,A}=01; following edge
//      Y=D1 (e.g. 4'hA), bus_valid=1. Drop req -> grant=0 next edge.
//   3. Fairness and timeout (HOLD_MAX=4, req=1111 held):
//      - grant=0001 for 4 cycles, timeout pulses, then 0010, 0100, 1000, 0001, ...
//      - each grant lasts 4 cycles with a timeout at every switch.
//   4. Handoff: grant=0001, req changes 0101 -> 0100 -> next edge grant=0100, {B,A}=10,
//      with no idle cycle and bus_valid staying 1.
//   5. RR pointer wrap: after a grant to index 1 (ptr=2), go idle, then req=1011
//      -> grant=1000; after its release with req=0011 -> grant=0001.
//   6. Reset mid-tenure: grant=0100, hold_cnt=2, reset pulsed -> all outputs zero, ptr=0;
//      then req=1100 -> grant=0100.

Source files
------------

// File: rtl/quad_bus_arbiter_if.sv
// Bus bundle between four requesting masters and the shared 4:1 mux arbiter.
// master = requester side, slave = arbiter side.
interface quad_bus_arbiter_if #(
  parameter int N = 4
);
  logic [3:0]   req;
  logic [N-1:0] D0;
  logic [N-1:0] D1;
  logic [N-1:0] D2;
  logic [N-1:0] D3;
  logic         A;
  logic         B;
  logic [3:0]   grant;
  logic [N-1:0] Y;
  logic         bus_valid;
  logic         timeout;

  modport master (
    output req, D0, D1, D2, D3,
    input  A, B, grant, Y, bus_valid, timeout
  );

  modport slave (
    input  req, D0, D1, D2, D3,
    output A, B, grant, Y, bus_valid, timeout
  );
endinterface

// File: rtl/quad_bus_arbiter.sv
// Round-robin arbiter for four requesters sharing one N-bit 4:1 mux, with a
// per-tenure hold limit and a registered mux output one cycle behind the select.
module quad_bus_arbiter #(
  parameter int N        = 4,
  parameter int HOLD_MAX = 8
) (
  input  logic                clk,
  input  logic                reset,
  quad_bus_arbiter_if.slave   bus
);

  localparam int             CW        = $clog2(HOLD_MAX);
  localparam logic [CW-1:0]  HOLD_LAST = CW'(HOLD_MAX - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t        state_q,     state_d;
  logic [3:0]    grant_q,     grant_d;
  logic [1:0]    sel_q,       sel_d;
  logic [1:0]    ptr_q,       ptr_d;
  logic [CW-1:0] hold_q,      hold_d;
  logic [N-1:0]  y_q,         y_d;
  logic          bus_valid_q, bus_valid_d;
  logic          timeout_q,   timeout_d;

  logic [1:0]    win;
  logic          take;
  logic [N-1:0]  mux_out;

  // First requester found scanning ptr, ptr+1, ... (mod 4).
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    logic [1:0] pick;
    logic       found;
    pick  = p;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = p + 2'(k);
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  always_comb begin
    mux_out = bus.D0;
    case (sel_q)
      2'd0: mux_out = bus.D0;
      2'd1: mux_out = bus.D1;
      2'd2: mux_out = bus.D2;
      2'd3: mux_out = bus.D3;
      default: mux_out = bus.D0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    take      = 1'b0;
    win       = rr_pick(bus.req, ptr_q);

    case (state_q)
      IDLE: begin
        if (|bus.req) take = 1'b1;
      end
      BUSY: begin
        if (bus.req[sel_q]) begin
          if (hold_q != HOLD_LAST) begin
            hold_d = hold_q + CW'(1);
          end else begin
            // ptr already points past the grantee, so it ranks last in the rescan.
            timeout_d = 1'b1;
            take      = 1'b1;
          end
        end else if (|bus.req) begin
          take = 1'b1;
        end else begin
          state_d = IDLE;
          grant_d = 4'b0000;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 4'b0000;
      end
    endcase

    if (take) begin
      state_d = BUSY;
      grant_d = 4'b0001 << win;
      sel_d   = win;
      hold_d  = '0;
      ptr_d   = win + 2'd1;
    end

    // Output register samples the select in force this cycle; holds when idle.
    bus_valid_d = (state_q == BUSY);
    y_d         = (state_q == BUSY) ? mux_out : y_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= 4'b0000;
      sel_q       <= 2'd0;
      ptr_q       <= 2'd0;
      hold_q      <= '0;
      y_q         <= '0;
      bus_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      sel_q       <= sel_d;
      ptr_q       <= ptr_d;
      hold_q      <= hold_d;
      y_q         <= y_d;
      bus_valid_q <= bus_valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.A         = sel_q[0];
  assign bus.B         = sel_q[1];
  assign bus.Y         = y_q;
  assign bus.bus_valid = bus_valid_q;
  assign bus.timeout   = timeout_q;

  a_grant_onehot0: assert property (@(posedge clk) disable iff (reset)
    $onehot0(grant_q));
  a_grant_matches_sel: assert property (@(posedge clk) disable iff (reset)
    (state_q == BUSY) |-> (grant_q == (4'b0001 << sel_q)));
  a_idle_no_grant: assert property (@(posedge clk) disable iff (reset)
    (state_q == IDLE) |-> (grant_q == 4'b0000));

endmodule

// File: tb/tb_quad_bus_arbiter.sv
// Scoreboard bench for quad_bus_arbiter: a tenure-level reference model predicts
// each cycle's outputs, a monitor pops and compares them one clock later.
module tb_quad_bus_arbiter;
  localparam int N        = 4;
  localparam int HOLD_MAX = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  quad_bus_arbiter_if #(.N(N)) bus ();

  quad_bus_arbiter #(.N(N), .HOLD_MAX(HOLD_MAX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [3:0]   grant;
    logic [1:0]   sel;
    logic [N-1:0] y;
    logic         bv;
    logic         to;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;
  bit   armed  = 1'b0;

  // Reference model: owner index (-1 = nobody), cycles held so far, priority pointer.
  int           m_owner  = -1;
  int           m_tenure = 0;
  int           m_ptr    = 0;
  int           m_sel    = 0;
  logic [N-1:0] m_y      = '0;
  bit           m_bv     = 1'b0;
  bit           m_to     = 1'b0;

  function automatic void m_pick(input logic [3:0] r);
    for (int k = 0; k < 4; k++) begin
      int idx;
      idx = (m_ptr + k) % 4;
      if (r[idx]) begin
        m_owner  = idx;
        m_sel    = idx;
        m_ptr    = (idx + 1) % 4;
        m_tenure = 1;
        return;
      end
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
  endtask

  task automatic drive(input logic rst_i, input logic [3:0] r);
    logic [N-1:0] d [4];
    logic [N-1:0] ny;
    bit           nb;
    bit           to;
    exp_t         e;
    @(negedge clk);
    for (int k = 0; k < 4; k++) d[k] = N'($urandom);
    reset   = rst_i;
    bus.req = r;
    bus.D0  = d[0];
    bus.D1  = d[1];
    bus.D2  = d[2];
    bus.D3  = d[3];
    if (rst_i) begin
      m_owner = -1; m_tenure = 0; m_ptr = 0; m_sel = 0;
      m_y = '0; m_bv = 1'b0; m_to = 1'b0;
    end else begin
      nb = (m_owner >= 0);
      ny = nb ? d[m_sel] : m_y;
      to = 1'b0;
      if (m_owner < 0) begin
        if (r != 4'b0000) m_pick(r);
      end else if (r[m_owner] && m_tenure < HOLD_MAX) begin
        m_tenure++;
      end else if (!r[m_owner]) begin
        if (r != 4'b0000) m_pick(r);
        else m_owner = -1;
      end else begin
        to = 1'b1;
        m_pick(r);
      end
      m_y = ny; m_bv = nb; m_to = to;
    end
    e.grant = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
    e.sel   = 2'(m_sel);
    e.y     = m_y;
    e.bv    = m_bv;
    e.to    = m_to;
    exp_q.push_back(e);
    armed = 1'b1;
  endtask

  task automatic hold_req(input logic [3:0] r, input int n);
    for (int i = 0; i < n; i++) drive(1'b0, r);
  endtask

  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("grant",     bus.grant,       e.grant);
      chk("select_BA", {bus.B, bus.A},  e.sel);
      chk("Y",         bus.Y,           e.y);
      chk("bus_valid", bus.bus_valid,   e.bv);
      chk("timeout",   bus.timeout,     e.to);
    end else if (armed) begin
      chk("scoreboard_underflow", 32'd0, 32'd1);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got %0d checks, expected completion", checks);
    $fatal(1);
  end

  initial begin
    logic [3:0] want;
    logic       rst_r;
    reset   = 1'b1;
    bus.req = 4'b0000;
    bus.D0  = '0; bus.D1 = '0; bus.D2 = '0; bus.D3 = '0;

    // Reset
    drive(1'b1, 4'b0000);
    drive(1'b1, 4'b0000);
    hold_req(4'b0000, 2);
    // Single request then release
    hold_req(4'b0010, 4);
    hold_req(4'b0000, 3);
    // Fairness and timeout with all four requesting
    hold_req(4'b1111, 24);
    hold_req(4'b0000, 2);
    // Handoff without idle bubble
    drive(1'b1, 4'b0000);
    hold_req(4'b0001, 2);
    hold_req(4'b0101, 1);
    hold_req(4'b0100, 3);
    hold_req(4'b0000, 2);
    // Pointer wrap
    drive(1'b1, 4'b0000);
    hold_req(4'b0010, 2);
    hold_req(4'b0000, 2);
    hold_req(4'b1011, 2);
    hold_req(4'b0011, 3);
    hold_req(4'b0000, 2);
    // Reset mid-tenure
    drive(1'b1, 4'b0000);
    hold_req(4'b0100, 3);
    drive(1'b1, 4'b0100);
    hold_req(4'b1100, 3);
    hold_req(4'b0000, 2);
    // Lone requester hitting the hold limit is re-granted
    hold_req(4'b1000, 10);
    hold_req(4'b0000, 2);

    // Random request churn with occasional resets
    want = 4'b0000;
    for (int i = 0; i < 800; i++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(7) == 0) want[b] = ~want[b];
      rst_r = ($urandom_range(99) == 0);
      drive(rst_r, want);
    end
    hold_req(4'b0000, 2);

    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
